// File: rtl/mm_ram_data_arbiter.sv
// Round-robin arbiter sharing the mm_ram data port between NUM_MASTERS
// requesters. Uses the req/gnt/rvalid protocol on every port and keeps an
// in-order ID FIFO so each response is routed back to the master that
// issued the matching request.
//
// Handshake: a request is accepted in the cycle where req and gnt are both
// high (gnt may only be high while req is high). Every accepted request
// receives exactly one rvalid pulse, at least one cycle after its grant,
// in issue order. rdata is meaningful only in a cycle where rvalid is high.
module mm_ram_data_arbiter #(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_MASTERS-1:0]             m_req_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS*4-1:0]           m_be_i,
  input  logic [NUM_MASTERS*32-1:0]          m_wdata_i,
  output logic [NUM_MASTERS-1:0]             m_gnt_o,
  output logic [NUM_MASTERS-1:0]             m_rvalid_o,
  output logic [31:0]                        m_rdata_o,
  output logic                               s_req_o,
  output logic [ADDR_WIDTH-1:0]              s_addr_o,
  output logic                               s_we_o,
  output logic [3:0]                         s_be_o,
  output logic [31:0]                        s_wdata_o,
  input  logic                               s_gnt_i,
  input  logic                               s_rvalid_i,
  input  logic [31:0]                        s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [IW-1:0] rr_ptr;
  logic          lock_q;
  logic [IW-1:0] lock_idx_q;
  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic [IW-1:0] sel;
  logic          sel_valid;
  logic [IW-1:0] cand;
  logic          full;
  logic          empty;
  logic          grant;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Selection: a stalled (locked) master keeps the port; otherwise scan from rr_ptr.
  // A locked master that drops its request loses the lock and normal
  // round-robin scanning takes over in that same cycle.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    cand      = '0;
    if (lock_q && m_req_i[lock_idx_q]) begin
      sel       = lock_idx_q;
      sel_valid = 1'b1;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        cand = IW'((int'(rr_ptr) + i) % NUM_MASTERS);
        if (!sel_valid && m_req_i[cand]) begin
          sel       = cand;
          sel_valid = 1'b1;
        end
      end
    end
  end

  assign full  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);

  // Reset gates the issue path so a reset pulse silences the slave side at once.
  assign s_req_o = rst_ni & sel_valid & ~full;
  assign grant   = s_req_o & s_gnt_i;
  assign pop     = rst_ni & s_rvalid_i & ~empty;

  // Slave-side request mux and per-master grant / response routing.
  always_comb begin
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (sel_valid) begin
      s_addr_o  = m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
      s_we_o    = m_we_i[sel];
      s_be_o    = m_be_i[sel*4 +: 4];
      s_wdata_o = m_wdata_i[sel*32 +: 32];
    end
    m_gnt_o[sel]             = grant;
    m_rvalid_o[fifo_q[rd_ptr]] = pop;
  end

  assign m_rdata_o     = s_rdata_i;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

  // Arbitration state: lock holds a pending selection until it is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= sel_valid & ~grant;
      lock_idx_q <= sel;
      if (grant) begin
        rr_ptr <= (sel == IW'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  // Outstanding-ID FIFO: push on grant, pop on a response, count tracks both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (grant) begin
        fifo_q[wr_ptr] <= sel;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({grant, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky protocol error: response with nothing outstanding, or a stray grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((s_rvalid_i && empty) || (s_gnt_i && !s_req_o)) begin
      err_q <= 1'b1;
    end
  end

endmodule
